// File: rtl/sfp_acc_if.sv
// Bus between the psum SRAM read side and the SFP accumulate unit.
// Master drives the strobes and read data; slave returns the finalized results.
interface sfp_acc_if #(
  parameter int unsigned PsumBw = 16,
  parameter int unsigned Col    = 8
);
  logic                   acc;
  logic                   relu;
  logic [PsumBw*Col-1:0]  psum_in;
  logic [PsumBw*Col-1:0]  sfp_out;
  logic                   out_valid;
  logic [3:0]             acc_cnt;
  logic                   cnt_err;
  logic [Col-1:0]         ovf;

  modport master (
    output acc, relu, psum_in,
    input  sfp_out, out_valid, acc_cnt, cnt_err, ovf
  );

  modport slave (
    input  acc, relu, psum_in,
    output sfp_out, out_valid, acc_cnt, cnt_err, ovf
  );
endinterface

// File: rtl/sfp_acc_unit.sv
// Per-column psum accumulator with ReLU finalize, beat counting and sticky overflow flags.
// One instance covers every output column; columns never interact.
module sfp_acc_unit #(
  parameter int unsigned PsumBw = 16,
  parameter int unsigned Col    = 8,
  parameter int unsigned LenKij = 9
) (
  input  logic       clk,
  input  logic       reset,
  sfp_acc_if.slave   bus
);

  localparam logic [3:0] LenKijW = 4'(LenKij);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                        state_q, state_d;
  logic [Col-1:0][PsumBw-1:0]    accum_q, accum_d;
  logic [Col-1:0][PsumBw-1:0]    sfp_q, sfp_d;
  logic [Col-1:0][PsumBw-1:0]    psum, base, sum, fin;
  logic [3:0]                    cnt_q, cnt_d, cnt_inc, cnt_fin;
  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic [Col-1:0]                ovf_q, ovf_d, ovf_now;

  assign psum = bus.psum_in;

  // A beat taken outside ACCUM starts a fresh sum from zero.
  always_comb begin
    for (int c = 0; c < Col; c++) begin
      base[c]    = (state_q == StAccum) ? accum_q[c] : '0;
      sum[c]     = base[c] + psum[c];
      ovf_now[c] = (base[c][PsumBw-1] == psum[c][PsumBw-1]) &&
                   (sum[c][PsumBw-1] != base[c][PsumBw-1]);
    end
  end

  always_comb begin
    if (state_q != StAccum) begin
      cnt_inc = 4'd1;
    end else if (cnt_q == 4'hF) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + 4'd1;
    end
  end

  // With acc and relu together the beat is folded in before ReLU and the count check.
  assign fin     = bus.acc ? sum : accum_q;
  assign cnt_fin = bus.acc ? cnt_inc : cnt_q;

  always_comb begin
    state_d = state_q;
    accum_d = accum_q;
    sfp_d   = sfp_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovf_d   = ovf_q;

    if (bus.acc) begin
      accum_d = sum;
      cnt_d   = cnt_inc;
      ovf_d   = ovf_q | ovf_now;
      valid_d = 1'b0;
      state_d = StAccum;
    end

    if (bus.relu) begin
      if (bus.acc || (state_q == StAccum)) begin
        for (int c = 0; c < Col; c++) begin
          sfp_d[c] = fin[c][PsumBw-1] ? '0 : fin[c];
        end
        err_d   = err_q | (cnt_fin != LenKijW);
        valid_d = 1'b1;
        cnt_d   = 4'd0;
        state_d = StDone;
      end else if (state_q == StIdle) begin
        sfp_d   = '0;
        err_d   = err_q | (cnt_q != LenKijW);
        valid_d = 1'b1;
        cnt_d   = 4'd0;
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      accum_q <= '0;
      sfp_q   <= '0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      accum_q <= accum_d;
      sfp_q   <= sfp_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sfp_out   = sfp_q;
  assign bus.out_valid = valid_q;
  assign bus.acc_cnt   = cnt_q;
  assign bus.cnt_err   = err_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sfp_acc_unit.sv
// Bench for sfp_acc_unit: table of pixel runs with hand-derived results, queued as expectations
// when driven and popped when the result appears, plus directed multi-cycle sequences.
module tb_sfp_acc_unit;
  localparam int unsigned PsumBw = 16;
  localparam int unsigned Col    = 8;
  localparam int unsigned LenKij = 9;
  localparam int unsigned W      = PsumBw * Col;
  localparam int unsigned NVec   = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfp_acc_if #(.PsumBw(PsumBw), .Col(Col)) bus ();

  sfp_acc_unit #(.PsumBw(PsumBw), .Col(Col), .LenKij(LenKij)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int                 nbeats;
    bit                 relu_on_last;
    logic [8:0][W-1:0]  beat;
    logic [W-1:0]       exp_out;
    logic               exp_err;
    logic [Col-1:0]     exp_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0]   out;
    logic           err;
    logic [Col-1:0] ovf;
  } exp_t;

  vec_t vecs [NVec];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] splat(logic [PsumBw-1:0] v);
    logic [W-1:0] w;
    for (int c = 0; c < Col; c++) w[c*PsumBw +: PsumBw] = v;
    return w;
  endfunction

  function automatic logic [W-1:0] setcol(logic [W-1:0] w, int c, logic [PsumBw-1:0] v);
    logic [W-1:0] r;
    r = w;
    r[c*PsumBw +: PsumBw] = v;
    return r;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    reset = 1'b1;
    bus.acc = 1'b0;
    bus.relu = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic beat(logic [W-1:0] data, bit rl);
    bus.acc = 1'b1;
    bus.relu = rl;
    bus.psum_in = data;
    @(negedge clk);
    bus.acc = 1'b0;
    bus.relu = 1'b0;
    bus.psum_in = '0;
  endtask

  task automatic finalize();
    bus.relu = 1'b1;
    @(negedge clk);
    bus.relu = 1'b0;
  endtask

  task automatic check_result(string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h expected an entry", name, bus.sfp_out);
      return;
    end
    e = sb_q.pop_front();
    chk({name, " out_valid"}, W'(bus.out_valid), W'(1'b1));
    chk({name, " sfp_out"}, bus.sfp_out, e.out);
    chk({name, " cnt_err"}, W'(bus.cnt_err), W'(e.err));
    chk({name, " ovf"}, W'(bus.ovf), W'(e.ovf));
    chk({name, " acc_cnt"}, W'(bus.acc_cnt), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    exp_t e;

    reset = 1'b1;
    bus.acc = 1'b0;
    bus.relu = 1'b0;
    bus.psum_in = '0;

    // Table of pixel runs (expected values worked out by hand).
    vecs[0].nbeats = 9; vecs[0].relu_on_last = 0;
    for (int i = 0; i < 9; i++) vecs[0].beat[i] = splat(16'd3);
    vecs[0].exp_out = splat(16'h001b); vecs[0].exp_err = 0; vecs[0].exp_ovf = '0;

    vecs[1].nbeats = 9; vecs[1].relu_on_last = 0;
    for (int i = 0; i < 9; i++) begin
      w = '0;
      w = setcol(w, 0, (i < 8) ? 16'hfffb : 16'h0000);
      w = setcol(w, 1, (i < 8) ? 16'd11 : 16'd12);
      for (int c = 2; c < Col; c++) w = setcol(w, c, (i % 2 == 0) ? 16'd5 : 16'hfffb);
      vecs[1].beat[i] = w;
    end
    w = splat(16'd5);
    w = setcol(w, 0, 16'd0);
    w = setcol(w, 1, 16'd100);
    vecs[1].exp_out = w; vecs[1].exp_err = 0; vecs[1].exp_ovf = '0;

    vecs[2].nbeats = 9; vecs[2].relu_on_last = 0;
    for (int i = 0; i < 9; i++) vecs[2].beat[i] = setcol('0, 2, 16'h4000);
    vecs[2].exp_out = setcol('0, 2, 16'h4000); vecs[2].exp_err = 0; vecs[2].exp_ovf = 8'h04;

    vecs[3].nbeats = 8; vecs[3].relu_on_last = 0;
    for (int i = 0; i < 9; i++) vecs[3].beat[i] = splat(16'd1);
    vecs[3].exp_out = splat(16'd8); vecs[3].exp_err = 1; vecs[3].exp_ovf = '0;

    vecs[4].nbeats = 9; vecs[4].relu_on_last = 1;
    for (int i = 0; i < 9; i++) vecs[4].beat[i] = splat(16'd2);
    vecs[4].exp_out = splat(16'd18); vecs[4].exp_err = 0; vecs[4].exp_ovf = '0;

    vecs[5].nbeats = 9; vecs[5].relu_on_last = 0;
    for (int i = 0; i < 9; i++) vecs[5].beat[i] = splat(16'hffff);
    vecs[5].exp_out = '0; vecs[5].exp_err = 0; vecs[5].exp_ovf = '0;

    // Reset state, then relu from IDLE publishes zeros with a count error.
    do_reset(2);
    chk("reset sfp_out", bus.sfp_out, '0);
    chk("reset out_valid", W'(bus.out_valid), W'(1'b0));
    e.out = '0; e.err = 1'b1; e.ovf = '0;
    sb_q.push_back(e);
    finalize();
    check_result("idle_relu");

    // Dirty the sticky state mid-ACCUM, then a 2-cycle reset must wipe everything.
    beat(splat(16'h7fff), 0);
    beat(splat(16'h7fff), 0);
    chk("pre-reset ovf", W'(bus.ovf), W'(8'hff));
    do_reset(2);
    chk("midacc reset sfp_out", bus.sfp_out, '0);
    chk("midacc reset out_valid", W'(bus.out_valid), W'(1'b0));
    chk("midacc reset acc_cnt", W'(bus.acc_cnt), W'(0));
    chk("midacc reset ovf", W'(bus.ovf), W'(0));
    chk("midacc reset cnt_err", W'(bus.cnt_err), W'(1'b0));

    for (int v = 0; v < NVec; v++) begin
      if (v != 0) do_reset(1);
      e.out = vecs[v].exp_out; e.err = vecs[v].exp_err; e.ovf = vecs[v].exp_ovf;
      sb_q.push_back(e);
      for (int b = 0; b < vecs[v].nbeats; b++)
        beat(vecs[v].beat[b], vecs[v].relu_on_last && (b == vecs[v].nbeats - 1));
      if (!vecs[v].relu_on_last) begin
        chk($sformatf("vec%0d acc_cnt", v), W'(bus.acc_cnt), W'(vecs[v].nbeats));
        finalize();
      end
      check_result($sformatf("vec%0d", v));
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d hold sfp_out", v), bus.sfp_out, vecs[v].exp_out);
      chk($sformatf("vec%0d hold out_valid", v), W'(bus.out_valid), W'(1'b1));
    end

    // Overflow flag appears exactly on the wrapping beat and only for column 2.
    do_reset(1);
    beat(setcol('0, 2, 16'h4000), 0);
    chk("ovf after beat1", W'(bus.ovf), W'(0));
    beat(setcol('0, 2, 16'h4000), 0);
    chk("ovf after beat2", W'(bus.ovf), W'(8'h04));

    // Beat counter saturates at 15.
    do_reset(1);
    for (int b = 0; b < 16; b++) beat(splat(16'd1), 0);
    chk("acc_cnt saturate", W'(bus.acc_cnt), W'(15));
    e.out = splat(16'd16); e.err = 1'b1; e.ovf = '0;
    sb_q.push_back(e);
    finalize();
    check_result("saturate");

    // Back-to-back pixels with no reset between them.
    do_reset(1);
    e.out = splat(16'd27); e.err = 1'b0; e.ovf = '0;
    sb_q.push_back(e);
    for (int b = 0; b < 9; b++) beat(splat(16'd3), 0);
    finalize();
    check_result("b2b first");
    e.out = splat(16'd63); e.err = 1'b0; e.ovf = '0;
    sb_q.push_back(e);
    beat(splat(16'd7), 0);
    chk("b2b restart out_valid", W'(bus.out_valid), W'(1'b0));
    chk("b2b restart sfp_out held", bus.sfp_out, splat(16'd27));
    chk("b2b restart acc_cnt", W'(bus.acc_cnt), W'(1));
    for (int b = 1; b < 9; b++) beat(splat(16'd7), 0);
    finalize();
    check_result("b2b second");

    // A second relu in DONE changes nothing.
    finalize();
    chk("done relu sfp_out", bus.sfp_out, splat(16'd63));
    chk("done relu out_valid", W'(bus.out_valid), W'(1'b1));
    chk("done relu cnt_err", W'(bus.cnt_err), W'(1'b0));

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
